// File: rtl/wave_rom_sequencer.sv
// Phase-accumulator ROM sequencer: walks a synchronous-read waveform ROM and streams
// one frame of samples through a 2-entry skid FIFO onto a valid/ready output.
module wave_rom_sequencer #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int PHASE_WIDTH = 16,
  parameter int FRAME_LEN   = 128
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [PHASE_WIDTH-1:0] freq_word_i,
  input  logic [PHASE_WIDTH-1:0] phase_init_i,
  output logic [ADDR_WIDTH-1:0]  rom_addr_o,
  input  logic [DATA_WIDTH-1:0]  rom_data_i,
  output logic [DATA_WIDTH-1:0]  out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   out_last_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                 state_q;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] freq_q;
  logic [CNT_W-1:0]       issued_q, beat_q;
  logic                   inflight_q;
  logic [DATA_WIDTH-1:0]  fifo_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             count_q;
  logic                   done_q;

  logic       pop;
  logic       issue;
  logic [2:0] occ;

  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = fifo_q[rd_ptr_q];
  assign out_last_o  = out_valid_o && (beat_q == LAST_BEAT);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign rom_addr_o  = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign pop         = out_valid_o && out_ready_i;

  // Stored plus in-flight samples may never exceed the two FIFO slots.
  always_comb begin
    occ     = 3'(count_q) + 3'(inflight_q);
    issue   = (state_q == S_RUN) && (issued_q < FRAME_CNT) && ((occ - 3'(pop)) < 3'd2);
    phase_d = phase_q;
    if (issue) phase_d = phase_q + freq_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      freq_q     <= '0;
      issued_q   <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      done_q     <= 1'b0;
    end else if (abort_i) begin
      state_q    <= S_IDLE;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      phase_q    <= phase_d;
      if (issue) issued_q <= issued_q + 1'b1;
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= rom_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        beat_q   <= beat_q + 1'b1;
      end
      count_q <= count_q + 2'(inflight_q) - 2'(pop);
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q  <= S_RUN;
            freq_q   <= freq_word_i;
            phase_q  <= phase_init_i;
            issued_q <= '0;
            beat_q   <= '0;
          end
        end
        S_RUN: begin
          if (issued_q == FRAME_CNT) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && (beat_q == LAST_BEAT)) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_rom_sequencer.sv
// Scoreboard bench for wave_rom_sequencer: expected samples are queued at frame start
// and a negedge monitor pops them on every handshake.
module tb_wave_rom_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [15:0] freq_word, phase_init;
  logic [6:0]  rom_addr;
  logic [7:0]  rom_data, out_data;
  logic        out_valid, out_last, busy, done;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  rom [128];
  int          vectors = 0;
  int          errors = 0;
  int          beats_frame = 0;
  int          done_cnt = 0;
  int          rdy_mode = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  wave_rom_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .freq_word_i(freq_word), .phase_init_i(phase_init),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_last_o(out_last), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 128; i++) rom[i] = 8'(i * 37 + 11);

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_data", 32'(out_data), 32'(e.data));
          chk("beat_last", 32'(out_last), 32'(e.last));
        end
        beats_frame++;
      end
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] fw, input logic [15:0] pi);
    logic [15:0] ph;
    for (int k = 0; k < 128; k++) begin
      exp_t e;
      ph     = pi + 16'(k) * fw;
      e.data = rom[ph[15:9]];
      e.last = (k == 127);
      exp_q.push_back(e);
    end
    beats_frame = 0;
    freq_word   = fw;
    phase_init  = pi;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      step();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("frame_beats", 32'(beats_frame), 32'd128);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats_frame < target && n < 500) begin
      step();
      n++;
    end
    chk("reach_beat", 32'(beats_frame), 32'(target));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_addr"}, 32'(rom_addr), 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    freq_word = '0; phase_init = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Cycle-exact frame: addresses 0..127 in cycles 1..128, valid 3..130, done 131.
    start_frame(16'h0200, 16'h0000);
    for (int c = 1; c <= 131; c++) begin
      if (c <= 128) chk("t1_addr", 32'(rom_addr), 32'(c - 1));
      chk("t1_valid", 32'(out_valid), 32'((c >= 3) && (c <= 130)));
      chk("t1_last", 32'(out_last), 32'(c == 130));
      chk("t1_done", 32'(done), 32'(c == 131));
      chk("t1_busy", 32'(busy), 32'(c <= 130));
      step();
    end
    chk("t1_beats", 32'(beats_frame), 32'd128);
    chk("t1_queue", 32'(exp_q.size()), 32'd0);

    // Modulo wrap: 127, 2, 5, ...
    start_frame(16'h0600, 16'hFE00);
    chk("t2_addr0", 32'(rom_addr), 32'd127);
    step();
    chk("t2_addr1", 32'(rom_addr), 32'd2);
    step();
    chk("t2_addr2", 32'(rom_addr), 32'd5);
    wait_done(400);

    // Toggling ready, with a start pulse and freq_word change mid-frame.
    rdy_mode = 1;
    start_frame(16'h0200, 16'h1234);
    repeat (40) step();
    freq_word = 16'h0700; phase_init = 16'h0000; start = 1'b1;
    step();
    start = 1'b0;
    freq_word = 16'h0100;
    wait_done(800);
    rdy_mode = 0;
    step();

    // Output stalled for 20 cycles: only two reads may be issued.
    rdy_mode = 2; out_ready = 1'b0;
    start_frame(16'h0200, 16'h0000);
    repeat (19) step();
    chk("t4_addr_stall", 32'(rom_addr), 32'd2);
    chk("t4_valid_stall", 32'(out_valid), 32'd1);
    chk("t4_beats_stall", 32'(beats_frame), 32'd0);
    rdy_mode = 0; out_ready = 1'b1;
    wait_done(400);
    step();

    // Abort at beat 50 together with start.
    start_frame(16'h0300, 16'h0400);
    wait_beats(50);
    d0 = done_cnt;
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_last", 32'(out_last), 32'd0);
    exp_q.delete();
    repeat (10) step();
    chk("t5_no_done", 32'(done_cnt), 32'(d0));
    chk("t5_idle", 32'(busy), 32'd0);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("t5_abort_beats_start", 32'(busy), 32'd0);
    step();
    start_frame(16'h0300, 16'h0400);
    wait_done(400);
    step();

    // Reset at beat 10 discards the frame.
    start_frame(16'h0500, 16'h0000);
    wait_beats(10);
    d0 = done_cnt;
    rst = 1'b1;
    step();
    chk_reset_outputs("t6");
    rst = 1'b0;
    exp_q.delete();
    repeat (5) step();
    chk("t6_no_done", 32'(done_cnt), 32'(d0));
    chk("t6_idle", 32'(busy), 32'd0);
    start_frame(16'h0200, 16'h0000);
    wait_done(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
